// File: rtl/vga_capture.sv
// VGA sync-stream capture: recovers pixel position and active video from hsync/vsync,
// measures line/frame timing and reports lock once it matches the configured mode.
module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BP        = 48,
  parameter int H_SYNC      = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_BP        = 33,
  parameter int V_SYNC      = 2,
  parameter int V_TOTAL     = 525,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        px_clk,
  input  logic        resetn,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic [9:0]  x_px,
  output logic [9:0]  y_px,
  output logic        active,
  output logic [2:0]  rgb_o,
  output logic        locked,
  output logic        frame_done,
  output logic [18:0] lit_count,
  output logic [9:0]  h_meas,
  output logic [9:0]  v_meas,
  output logic        err,
  output logic [7:0]  err_cnt
);
  localparam logic [9:0] H0 = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H1 = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V0 = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V1 = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] HT = 10'(H_TOTAL);
  localparam logic [9:0] VT = 10'(V_TOTAL);
  localparam int WD_LIM = 2 * H_TOTAL;
  localparam int WD_W   = $clog2(WD_LIM + 1);
  localparam int GW     = $clog2(LOCK_FRAMES + 1);
  localparam logic IDLE_LVL = ~SYNC_POL;

  typedef enum logic [1:0] {UNLOCKED, SEARCH, LOCKED} state_t;

  state_t            state;
  logic              s_hsync, s_vsync, s_hsync_d, s_vsync_d;
  logic [2:0]        s_rgb;
  logic [9:0]        h_cnt, v_cnt;
  logic [18:0]       lit_acc;
  logic              line_bad;
  logic [WD_W-1:0]   wd;
  logic [GW-1:0]     good;

  logic              h_edge, v_edge, line_ok, frame_ok, in_act, lit_inc, wd_exp;
  logic [9:0]        h_inc, v_inc, h_nxt, v_nxt;
  logic [18:0]       lit_sum;

  assign h_edge  = (s_hsync == SYNC_POL) && (s_hsync_d != SYNC_POL);
  assign v_edge  = (s_vsync == SYNC_POL) && (s_vsync_d != SYNC_POL);
  assign h_inc   = (h_cnt == 10'd1023) ? h_cnt : h_cnt + 10'd1;
  assign v_inc   = (v_cnt == 10'd1023) ? v_cnt : v_cnt + 10'd1;
  // Counters as they apply to the sample now sitting in s_*; outputs are derived from these.
  assign h_nxt   = h_edge ? 10'd0 : h_inc;
  assign v_nxt   = v_edge ? 10'd0 : (h_edge ? v_inc : v_cnt);
  assign in_act  = (h_nxt >= H0) && (h_nxt < H1) && (v_nxt >= V0) && (v_nxt < V1);
  assign lit_inc = in_act && (s_rgb != 3'd0);
  assign lit_sum = lit_acc + 19'(lit_inc);
  assign line_ok = (h_inc == HT);
  // A line closing on the same edge as the frame still belongs to the frame being judged.
  assign frame_ok = (v_inc == VT) && !line_bad && !(h_edge && !line_ok);
  assign wd_exp  = !h_edge && (wd == WD_W'(WD_LIM - 1));

  always_ff @(posedge px_clk) begin
    if (!resetn) begin
      s_hsync    <= IDLE_LVL;
      s_vsync    <= IDLE_LVL;
      s_hsync_d  <= IDLE_LVL;
      s_vsync_d  <= IDLE_LVL;
      s_rgb      <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      lit_acc    <= '0;
      line_bad   <= 1'b0;
      wd         <= '0;
      good       <= '0;
      state      <= UNLOCKED;
      x_px       <= '0;
      y_px       <= '0;
      active     <= 1'b0;
      rgb_o      <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      lit_count  <= '0;
      h_meas     <= '0;
      v_meas     <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      s_hsync   <= hsync;
      s_vsync   <= vsync;
      s_rgb     <= rgb;
      s_hsync_d <= s_hsync;
      s_vsync_d <= s_vsync;
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;

      active     <= in_act;
      x_px       <= in_act ? h_nxt - H0 : 10'd0;
      y_px       <= in_act ? v_nxt - V0 : 10'd0;
      rgb_o      <= in_act ? s_rgb : 3'd0;
      frame_done <= v_edge;

      if (v_edge) begin
        lit_count <= lit_sum;
        lit_acc   <= '0;
        v_meas    <= v_inc;
      end else begin
        lit_acc   <= lit_sum;
      end
      if (h_edge) h_meas <= h_inc;

      if (v_edge) line_bad <= 1'b0;
      else if (h_edge && !line_ok) line_bad <= 1'b1;

      if (h_edge) wd <= '0;
      else if (wd != WD_W'(WD_LIM)) wd <= wd + WD_W'(1);

      err <= 1'b0;
      if (wd_exp) begin
        if (state == LOCKED) begin
          err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        state  <= UNLOCKED;
        good   <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          UNLOCKED: if (v_edge) begin
            state <= SEARCH;
            good  <= '0;
          end
          SEARCH: if (v_edge) begin
            if (!frame_ok) good <= '0;
            else if (good == GW'(LOCK_FRAMES - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
              good   <= '0;
            end else good <= good + GW'(1);
          end
          LOCKED: if ((h_edge && !line_ok) || (v_edge && !frame_ok)) begin
            err    <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state  <= SEARCH;
            good   <= '0;
            locked <= 1'b0;
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a scaled-down video mode; a geometry model predicts the
// capture outputs and lit counts, scenario knowledge predicts lock/err behaviour.
module tb_vga_capture;
  localparam int HA = 16, HB = 4, HS = 4, HT = 28;
  localparam int VA = 12, VB = 2, VS = 2, VT = 18;
  localparam int H0 = HS + HB, V0 = VS + VB;

  logic        px_clk = 1'b0, resetn = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [2:0]  rgb = '0;
  logic [9:0]  x_px, y_px, h_meas, v_meas;
  logic        active, locked, frame_done, err;
  logic [2:0]  rgb_o;
  logic [18:0] lit_count;
  logic [7:0]  err_cnt;

  always #5 px_clk = ~px_clk;

  vga_capture #(
    .H_ACTIVE(HA), .H_BP(HB), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BP(VB), .V_SYNC(VS), .V_TOTAL(VT),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .px_clk(px_clk), .resetn(resetn), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .x_px(x_px), .y_px(y_px), .active(active), .rgb_o(rgb_o), .locked(locked),
    .frame_done(frame_done), .lit_count(lit_count), .h_meas(h_meas), .v_meas(v_meas),
    .err(err), .err_cnt(err_cnt)
  );

  typedef struct { bit chk; bit act; int x; int y; int c; } exp_t;

  int    checks = 0, failures = 0;
  int    cap_cmp = 0, cap_bad = 0;
  string cap_msg = "";
  int    err_seen = 0, fd_seen = 0;
  int    lit_acc_m = 0, lit_last_m = 0;
  bit    sq_mode = 1'b0;
  exp_t  pipe0 = '{1'b0, 1'b0, 0, 0, 0};
  exp_t  pipe1 = '{1'b0, 1'b0, 0, 0, 0};
  exp_t  e_now = '{1'b0, 1'b0, 0, 0, 0};
  exp_t  e_zero = '{1'b1, 1'b0, 0, 0, 0};
  exp_t  e_none = '{1'b0, 1'b0, 0, 0, 0};

  // One pixel clock: observe what is visible now, then drive the next sample.
  task automatic cyc(input bit rst, input bit hs, input bit vs, input logic [2:0] c, input exp_t e);
    @(negedge px_clk);
    e_now = pipe1;
    if (e_now.chk) begin
      cap_cmp++;
      if (active !== e_now.act || x_px !== 10'(e_now.x) || y_px !== 10'(e_now.y) ||
          rgb_o !== 3'(e_now.c)) begin
        cap_bad++;
        if (cap_bad == 1)
          cap_msg = $sformatf("t=%0t got act=%0b x=%0d y=%0d rgb=%0d want act=%0b x=%0d y=%0d rgb=%0d",
                              $time, active, x_px, y_px, rgb_o, e_now.act, e_now.x, e_now.y, e_now.c);
      end
    end
    err_seen += int'(err);
    fd_seen  += int'(frame_done);
    resetn = !rst; hsync = hs; vsync = vs; rgb = c;
    pipe1 = pipe0;
    pipe0 = e;
    if (rst) begin pipe1 = e_zero; pipe0 = e_zero; end
  endtask

  task automatic send_frame(input int nlines, input int short_l);
    for (int l = 0; l < nlines; l++) begin
      int len = (l == short_l) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        bit act = (c >= H0) && (c < H0 + HA) && (l >= V0) && (l < V0 + VA);
        logic [2:0] col;
        if (sq_mode) col = (act && c - H0 >= 2 && c - H0 <= 11 && l - V0 >= 1 && l - V0 <= 10) ? 3'd7 : 3'd0;
        else col = 3'($urandom_range(0, 7));
        if (l == 0 && c == 0) begin lit_last_m = lit_acc_m; lit_acc_m = 0; end
        if (act && col != 3'd0) lit_acc_m++;
        cyc(1'b0, !(c < HS), !(l < VS), col,
            '{1'b1, act, act ? c - H0 : 0, act ? l - V0 : 0, act ? int'(col) : 0});
      end
    end
  endtask

  task automatic begin_test();
    cap_cmp = 0; cap_bad = 0; cap_msg = ""; err_seen = 0; fd_seen = 0;
  endtask

  task automatic test_reset();
    begin_test();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), e_none);
    checks++;
    if ({x_px, y_px, active, rgb_o, locked, frame_done, lit_count, h_meas, v_meas, err, err_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: x=%0d y=%0d act=%0b rgb=%0d lock=%0b fd=%0b lit=%0d hm=%0d vm=%0d err=%0b ec=%0d want all 0",
               x_px, y_px, active, rgb_o, locked, frame_done, lit_count, h_meas, v_meas, err, err_cnt);
    end
  endtask

  // Syncs are still asserted from the reset cycles: the first sample must count as an edge.
  task automatic test_lock();
    begin_test();
    send_frame(VT, -1);
    send_frame(VT, -1);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early: locked=%0b want 0", locked); end
    send_frame(VT, -1);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_after3: locked=%0b want 1", locked); end
    checks++; if (h_meas !== 10'(HT)) begin failures++; $display("FAIL lock_h_meas: got %0d want %0d", h_meas, HT); end
    checks++; if (v_meas !== 10'(VT)) begin failures++; $display("FAIL lock_v_meas: got %0d want %0d", v_meas, VT); end
    checks++; if (err_cnt !== 8'd0 || err_seen !== 0) begin failures++; $display("FAIL lock_err: err_cnt=%0d pulses=%0d want 0/0", err_cnt, err_seen); end
    checks++; if (fd_seen !== 3) begin failures++; $display("FAIL lock_frame_done: pulses=%0d want 3", fd_seen); end
    checks++; if (cap_bad !== 0 || cap_cmp == 0) begin failures++; $display("FAIL lock_capture: %0d of %0d wrong, %s", cap_bad, cap_cmp, cap_msg); end
  endtask

  task automatic test_capture();
    int rand_lit;
    begin_test();
    sq_mode = 1'b1;
    send_frame(VT, -1);
    sq_mode = 1'b0;
    send_frame(VT, -1);
    rand_lit = lit_acc_m;
    checks++; if (lit_count !== 19'd100) begin failures++; $display("FAIL lit_square: got %0d want 100", lit_count); end
    send_frame(VT, -1);
    checks++; if (lit_count !== 19'(rand_lit)) begin failures++; $display("FAIL lit_random: got %0d want %0d", lit_count, rand_lit); end
    checks++; if (locked !== 1'b1 || err_seen !== 0) begin failures++; $display("FAIL capture_lock: locked=%0b err pulses=%0d want 1/0", locked, err_seen); end
    checks++; if (fd_seen !== 3) begin failures++; $display("FAIL capture_frame_done: pulses=%0d want 3", fd_seen); end
    checks++; if (cap_bad !== 0 || cap_cmp == 0) begin failures++; $display("FAIL capture_pixels: %0d of %0d wrong, %s", cap_bad, cap_cmp, cap_msg); end
  endtask

  task automatic test_short_line();
    begin_test();
    send_frame(VT, $urandom_range(1, VT - 2));
    checks++; if (err_seen !== 1) begin failures++; $display("FAIL short_err_pulse: pulses=%0d want 1", err_seen); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL short_err_cnt: got %0d want 1", err_cnt); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL short_unlock: locked=%0b want 0", locked); end
    send_frame(VT, -1);
    send_frame(VT, -1);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL short_relock_early: locked=%0b want 0", locked); end
    send_frame(VT, -1);
    checks++; if (locked !== 1'b1 || err_cnt !== 8'd1) begin failures++; $display("FAIL short_relock: locked=%0b err_cnt=%0d want 1/1", locked, err_cnt); end
    checks++; if (cap_bad !== 0) begin failures++; $display("FAIL short_capture: %0d of %0d wrong, %s", cap_bad, cap_cmp, cap_msg); end
  endtask

  task automatic test_hsync_loss();
    begin_test();
    send_frame(6, -1);
    for (int i = 0; i < 2 * HT + 20; i++) cyc(1'b0, 1'b1, 1'b1, 3'($urandom_range(0, 7)), e_none);
    checks++; if (err_seen !== 1) begin failures++; $display("FAIL loss_err_pulse: pulses=%0d want 1", err_seen); end
    checks++; if (err_cnt !== 8'd2) begin failures++; $display("FAIL loss_err_cnt: got %0d want 2", err_cnt); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_unlock: locked=%0b want 0", locked); end
    send_frame(VT, -1);
    send_frame(VT, -1);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_relock_early: locked=%0b want 0", locked); end
    send_frame(VT, -1);
    checks++; if (locked !== 1'b1 || err_cnt !== 8'd2 || err_seen !== 1) begin
      failures++; $display("FAIL loss_relock: locked=%0b err_cnt=%0d pulses=%0d want 1/2/1", locked, err_cnt, err_seen);
    end
    checks++; if (cap_bad !== 0) begin failures++; $display("FAIL loss_capture: %0d of %0d wrong, %s", cap_bad, cap_cmp, cap_msg); end
  endtask

  task automatic test_reset_mid();
    begin_test();
    send_frame(9, -1);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL midreset_pre: locked=%0b want 1", locked); end
    cyc(1'b1, 1'b1, 1'b1, 3'($urandom_range(0, 7)), e_zero);
    cyc(1'b0, 1'b1, 1'b1, 3'd0, e_zero);
    checks++;
    if ({x_px, y_px, active, rgb_o, locked, frame_done, lit_count, h_meas, v_meas, err, err_cnt} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: x=%0d y=%0d act=%0b rgb=%0d lock=%0b fd=%0b lit=%0d hm=%0d vm=%0d err=%0b ec=%0d want all 0",
               x_px, y_px, active, rgb_o, locked, frame_done, lit_count, h_meas, v_meas, err, err_cnt);
    end
    send_frame(VT, -1);
    send_frame(VT, -1);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midreset_relock_early: locked=%0b want 0", locked); end
    send_frame(VT, -1);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL midreset_relock: locked=%0b want 1", locked); end
    checks++; if (cap_bad !== 0) begin failures++; $display("FAIL midreset_capture: %0d of %0d wrong, %s", cap_bad, cap_cmp, cap_msg); end
  endtask

  // A frame far longer than 1023 lines: the line counter must pin, not wrap.
  task automatic test_vsat();
    begin_test();
    send_frame(1030, -1);
    checks++; if (locked !== 1'b1 || v_meas !== 10'(VT)) begin
      failures++; $display("FAIL vsat_before: locked=%0b v_meas=%0d want 1/%0d", locked, v_meas, VT);
    end
    send_frame(VT, -1);
    checks++; if (v_meas !== 10'd1023) begin failures++; $display("FAIL vsat_v_meas: got %0d want 1023", v_meas); end
    checks++; if (locked !== 1'b0 || err_seen !== 1 || err_cnt !== 8'd1) begin
      failures++; $display("FAIL vsat_bad_frame: locked=%0b pulses=%0d err_cnt=%0d want 0/1/1", locked, err_seen, err_cnt);
    end
    checks++; if (cap_bad !== 0) begin failures++; $display("FAIL vsat_capture: %0d of %0d wrong, %s", cap_bad, cap_cmp, cap_msg); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_capture();
    test_short_line();
    test_hsync_loss();
    test_reset_mid();
    test_vsat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
